// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port memory.
// Each access takes IDLE->GRANT->ACCESS->DONE; the winner's request is latched at grant.
module mem_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DWIDTH-1:0] rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_de,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic              owner;
    logic              last_served;
    logic              winner;
    logic              lat_we;
    logic [AWIDTH-1:0] lat_addr;
    logic [DWIDTH-1:0] lat_wdata;

    // Under contention the requester not served last wins; a lone request always wins.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_served;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs decode only registered state, so an async reset clears them at once.
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        mem_addr   = '0;
        mem_wdata  = lat_wdata;
        mem_de     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        if (state != IDLE) begin
            gnt0     = ~owner;
            gnt1     = owner;
            mem_addr = lat_addr;
        end
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    next_state = GRANT;
                end
            end
            GRANT: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                next_state = DONE;
                mem_wr     = lat_we;
                mem_de     = lat_we;
                mem_rd     = ~lat_we;
            end
            DONE: begin
                next_state = IDLE;
                ack0       = ~owner;
                ack1       = owner;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner       <= 1'b0;
            last_served <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rdata       <= '0;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                owner     <= winner;
                lat_we    <= winner ? we1 : we0;
                lat_addr  <= winner ? addr1 : addr0;
                lat_wdata <= winner ? wdata1 : wdata0;
            end
            if (state == ACCESS && !lat_we) begin
                rdata <= mem_rdata;
            end
            if (state == DONE) begin
                last_served <= owner;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected accesses,
// a negedge monitor checks memory strobes and acks against the queue.
module tb_mem_arbiter;

    typedef struct {
        logic       id;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        int         ack_cyc;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [4:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, ack0, ack1, mem_de, mem_rd, mem_wr, busy;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;

    logic [7:0] mem [0:31] = '{default: 8'h00};
    txn_t       sb[$];
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    logic [7:0] last_rd = 8'h00;

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_de(mem_de), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Simple synchronous memory on the far side of the bus driver.
    always @(posedge clk) begin
        if (mem_wr && mem_de) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic id, input logic we, input logic [4:0] addr,
                                  input logic [7:0] data, input logic [7:0] exp_rd);
        txn_t t;
        @(posedge clk); #1;
        if (id) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
        end
        t.id = id; t.we = we; t.addr = addr; t.data = we ? data : exp_rd; t.ack_cyc = cyc + 3;
        sb.push_back(t);
    endtask

    task automatic release_reqs();
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            check_output("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Monitor: compares every memory strobe and every ack with the queue head.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_rd = 8'h00;
            end else begin
                if (busy) check_output("excl", {30'd0, gnt0 & gnt1, mem_rd & mem_de}, 32'd0);
                if (mem_wr || mem_rd || mem_de) begin
                    if (sb.size() == 0) begin
                        check_output("unexpected_access", {29'd0, mem_wr, mem_rd, mem_de}, 32'd0);
                    end else begin
                        t = sb[0];
                        check_output("access", {21'd0, mem_wr, mem_de, mem_rd, gnt0, gnt1, 1'b0, mem_addr},
                                     {21'd0, t.we, t.we, ~t.we, ~t.id, t.id, 1'b0, t.addr});
                        if (t.we) check_output("wdata", {24'd0, mem_wdata}, {24'd0, t.data});
                    end
                end
                if (ack0 || ack1) begin
                    if (sb.size() == 0) begin
                        check_output("unexpected_ack", {30'd0, ack0, ack1}, 32'd0);
                    end else begin
                        t = sb.pop_front();
                        check_output("ack_id", {30'd0, ack0, ack1}, {30'd0, ~t.id, t.id});
                        check_output("ack_cycle", 32'(cyc), 32'(t.ack_cyc));
                        if (!t.we) last_rd = t.data;
                        check_output("rdata", {24'd0, rdata}, {24'd0, last_rd});
                    end
                end
            end
        end
    end

    initial begin
        int k;
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_ctrl", {24'd0, busy, gnt0, gnt1, ack0, ack1, mem_rd, mem_wr, mem_de}, 32'd0);
        check_output("rst_rdata", {24'd0, rdata}, 32'd0);
        check_output("rst_addr", {27'd0, mem_addr}, 32'd0);
        check_output("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        repeat (10) begin
            @(negedge clk);
            check_output("idle", {26'd0, busy, mem_rd, mem_wr, mem_de, 2'b00}, 32'd0);
            check_output("idle_addr", {27'd0, mem_addr}, 32'd0);
        end

        // Requester 0 writes then reads back the same location.
        apply_stimulus(1'b0, 1'b1, 5'h0A, 8'hA5, 8'h00);
        release_reqs();
        wait_drain(20);
        apply_stimulus(1'b0, 1'b0, 5'h0A, 8'h00, 8'hA5);
        release_reqs();
        wait_drain(20);

        // Both requests held from reset: grants alternate starting with requester 0.
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h01; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h0A; wdata1 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            txn_t t;
            t.id = i[0]; t.we = ~i[0];
            t.addr = i[0] ? 5'h0A : 5'h01;
            t.data = i[0] ? 8'hA5 : 8'h11;
            t.ack_cyc = k + 3 + 4 * i;
            sb.push_back(t);
        end
        repeat (15) @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        wait_drain(20);

        // Lone requester 1 wins despite being served last; input changes during GRANT are ignored.
        apply_stimulus(1'b1, 1'b1, 5'h03, 8'h3C, 8'h00);
        @(posedge clk); #1;
        addr1 = 5'h1F; wdata1 = 8'hFF; req1 = 1'b0;
        wait_drain(20);
        check_output("mem_03", {24'd0, mem[3]}, 32'h3C);
        check_output("mem_1F", {24'd0, mem[31]}, 32'h00);
        apply_stimulus(1'b0, 1'b0, 5'h1F, 8'h00, 8'h00);
        release_reqs();
        wait_drain(20);

        // Requester 1 drops its request during ACCESS; the read still completes.
        apply_stimulus(1'b1, 1'b0, 5'h0A, 8'h00, 8'hA5);
        repeat (2) @(posedge clk);
        #1;
        req1 = 1'b0;
        wait_drain(20);

        // Reset during a write ACCESS clears the strobes without a clock edge.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h07; wdata0 = 8'h77;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        check_output("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("rst_async", {26'd0, mem_wr, mem_rd, mem_de, busy, ack0, ack1}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check_output("post_rst_busy", {31'd0, busy}, 32'd0);
        check_output("mem_07", {24'd0, mem[7]}, 32'h00);
        check_output("post_rst_rdata", {24'd0, rdata}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
